cla_adder32: RTL and testbench

//  Registered 32-bit carry-lookahead adder: sum_o/carry_o = a_i + b_i + carry_i.
//  Two-level CLA (4-bit groups plus group lookahead), no ripple chain.

---
 rtl/cla_pkg.sv | 11 +
 rtl/cla_group4.sv | 29 ++
 rtl/cla_adder32.sv | 101 ++++++++++
 tb/tb_cla_adder32.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared widths and types for the 32-bit carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH   = 32;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

  typedef logic [CLA_WIDTH-1:0]   cla_word_t;
  typedef logic [CLA_NGROUPS-1:0] cla_gvec_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: local sums from the group carry-in, plus the group
// generate/propagate terms consumed by the second-level lookahead.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       grp_g,
  output logic       grp_p
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Bit generate/propagate, flattened carries inside the group, and group G/P.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    s     = p ^ c;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
  end

endmodule

// File: rtl/cla_adder32.sv
// Registered 32-bit two-level carry-lookahead adder.
// {carry_o, sum_o} = a_i + b_i + carry_i, one cycle after the inputs are sampled.
// Optional feature: define CLA_OVERFLOW_EN to add the registered signed
// overflow output overflow_o (c[31] ^ c[32]).
module cla_adder32
  import cla_pkg::*;
(
  input  logic      clk_i,
  input  logic      areset_i,
  input  cla_word_t a_i,
  input  cla_word_t b_i,
  input  logic      carry_i,
  output cla_word_t sum_o,
  output logic      carry_o
`ifdef CLA_OVERFLOW_EN
  ,
  output logic      overflow_o
`endif
);

  cla_gvec_t                gg;   // group generate
  cla_gvec_t                gp;   // group propagate
  logic [CLA_NGROUPS:0]     cg;   // cg[k] = carry into bit 4k; cg[8] = carry out
  cla_word_t                sum_d;
  cla_word_t                sum_q;
  logic                     carry_d;
  logic                     carry_q;

  // Eight 4-bit groups, each fed by its lookahead carry.
  for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_grp
    cla_group4 u_grp (
      .a     (a_i[k*CLA_GROUP +: CLA_GROUP]),
      .b     (b_i[k*CLA_GROUP +: CLA_GROUP]),
      .cin   (cg[k]),
      .s     (sum_d[k*CLA_GROUP +: CLA_GROUP]),
      .grp_g (gg[k]),
      .grp_p (gp[k])
    );
  end

  // Second-level lookahead: every group carry is a flat sum of products of
  // group G/P and carry_i, so no carry ripples from group to group.
  always_comb begin
    cg[0] = carry_i;
    cg[1] = gg[0] | (gp[0] & carry_i);
    cg[2] = gg[1] | (gp[1] & gg[0]) | ((&gp[1:0]) & carry_i);
    cg[3] = gg[2] | (gp[2] & gg[1]) | ((&gp[2:1]) & gg[0]) | ((&gp[2:0]) & carry_i);
    cg[4] = gg[3] | (gp[3] & gg[2]) | ((&gp[3:2]) & gg[1]) | ((&gp[3:1]) & gg[0])
          | ((&gp[3:0]) & carry_i);
    cg[5] = gg[4] | (gp[4] & gg[3]) | ((&gp[4:3]) & gg[2]) | ((&gp[4:2]) & gg[1])
          | ((&gp[4:1]) & gg[0]) | ((&gp[4:0]) & carry_i);
    cg[6] = gg[5] | (gp[5] & gg[4]) | ((&gp[5:4]) & gg[3]) | ((&gp[5:3]) & gg[2])
          | ((&gp[5:2]) & gg[1]) | ((&gp[5:1]) & gg[0]) | ((&gp[5:0]) & carry_i);
    cg[7] = gg[6] | (gp[6] & gg[5]) | ((&gp[6:5]) & gg[4]) | ((&gp[6:4]) & gg[3])
          | ((&gp[6:3]) & gg[2]) | ((&gp[6:2]) & gg[1]) | ((&gp[6:1]) & gg[0])
          | ((&gp[6:0]) & carry_i);
    cg[8] = gg[7] | (gp[7] & gg[6]) | ((&gp[7:6]) & gg[5]) | ((&gp[7:5]) & gg[4])
          | ((&gp[7:4]) & gg[3]) | ((&gp[7:3]) & gg[2]) | ((&gp[7:2]) & gg[1])
          | ((&gp[7:1]) & gg[0]) | ((&gp[7:0]) & carry_i);
    carry_d = cg[8];
  end

  // Output register; reset clears it immediately and drops any in-flight result.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;

`ifdef CLA_OVERFLOW_EN
  logic c31;
  logic overflow_d;
  logic overflow_q;

  // Carry into bit 31 rebuilt from the top group's carry-in; overflow is the
  // disagreement between the carries into and out of the sign bit.
  always_comb begin
    c31 = (a_i[30] & b_i[30])
        | ((a_i[30] ^ b_i[30]) & a_i[29] & b_i[29])
        | ((a_i[30] ^ b_i[30]) & (a_i[29] ^ b_i[29]) & a_i[28] & b_i[28])
        | ((a_i[30] ^ b_i[30]) & (a_i[29] ^ b_i[29]) & (a_i[28] ^ b_i[28]) & cg[7]);
    overflow_d = c31 ^ cg[8];
  end

  // Overflow registered alongside the sum so both share the same latency.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_cla_adder32.sv
// Directed testbench for cla_adder32. Inputs change on the falling edge,
// outputs are checked 1 time unit after the rising edge that registers them.
module tb_cla_adder32;

  logic        clk_i;
  logic        areset_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        carry_i;
  logic [31:0] sum_o;
  logic        carry_o;
`ifdef CLA_OVERFLOW_EN
  logic        overflow_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {overflow, carry, sum} expected for each operand pair in flight
  logic [33:0] exp_q[$];

  cla_adder32 dut (
    .clk_i    (clk_i),
    .areset_i (areset_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .carry_i  (carry_i),
    .sum_o    (sum_o),
    .carry_o  (carry_o)
`ifdef CLA_OVERFLOW_EN
    ,
    .overflow_o (overflow_o)
`endif
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // reference: 33-bit add plus signed overflow from operand/result signs
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    logic [32:0] r;
    logic        ovf;
    r   = {1'b0, a} + {1'b0, b} + {32'd0, c};
    ovf = (a[31] == b[31]) && (r[31] != a[31]);
    return {ovf, r};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk_i);
    a_i = a; b_i = b; carry_i = c;
  endtask

  task automatic test_reset();
    areset_i = 1'b1;
    a_i = $urandom; b_i = $urandom; carry_i = 1'b1;
    #1;
    n_tests++;
    if (sum_o !== 32'd0 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: sum=%h carry=%b, need 0/0", sum_o, carry_o);
    end
    repeat (2) begin
      @(posedge clk_i); #1;
      a_i = $urandom; b_i = $urandom;
    end
    n_tests++;
    if (sum_o !== 32'd0 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: sum=%h carry=%b, need 0/0", sum_o, carry_o);
    end
`ifdef CLA_OVERFLOW_EN
    n_tests++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: ovf=%b, need 0", overflow_o);
    end
`endif
    @(negedge clk_i);
    areset_i = 1'b0;
    a_i = 32'd5; b_i = 32'd7; carry_i = 1'b0;
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'd12 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: sum=%0d carry=%b, need 12/0", sum_o, carry_o);
    end
  endtask

  task automatic test_small();
    logic [31:0] a, b;
    for (int i = 0; i < 11; i++) begin
      a = $urandom_range(1, 2000);
      b = $urandom_range(1, 2000);
      drive(a, b, 1'b0);
      @(posedge clk_i); #1;
      n_tests++;
      if (sum_o !== a + b || carry_o !== 1'b0) begin
        n_fail++;
        $display("FAIL small_%0d: %0d+%0d got sum=%0d carry=%b, need %0d/0",
                 i, a, b, sum_o, carry_o, a + b);
      end
    end
  endtask

  task automatic test_carry_chain();
    drive(32'hFFFF_FFFF, 32'd0, 1'b1);
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'd0 || carry_o !== 1'b1) begin
      n_fail++;
      $display("FAIL chain_full: sum=%h carry=%b, need 00000000/1", sum_o, carry_o);
    end
    drive(32'h0000_FFFF, 32'd1, 1'b0);
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'h0001_0000 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL chain_half: sum=%h carry=%b, need 00010000/0", sum_o, carry_o);
    end
    drive(32'hFFFF_FFFF, 32'd1, 1'b0);
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'd0 || carry_o !== 1'b1) begin
      n_fail++;
      $display("FAIL chain_wrap: sum=%h carry=%b, need 00000000/1", sum_o, carry_o);
    end
  endtask

  task automatic test_max();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'hFFFF_FFFF || carry_o !== 1'b1) begin
      n_fail++;
      $display("FAIL max: sum=%h carry=%b, need ffffffff/1", sum_o, carry_o);
    end
`ifdef CLA_OVERFLOW_EN
    n_tests++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL max_ovf: ovf=%b, need 0", overflow_o);
    end
    drive(32'h7FFF_FFFF, 32'd1, 1'b0);
    @(posedge clk_i); #1;
    n_tests++;
    if (overflow_o !== 1'b1 || sum_o !== 32'h8000_0000 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pos: ovf=%b sum=%h carry=%b, need 1/80000000/0",
               overflow_o, sum_o, carry_o);
    end
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    @(posedge clk_i); #1;
    n_tests++;
    if (overflow_o !== 1'b1 || sum_o !== 32'd0 || carry_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg: ovf=%b sum=%h carry=%b, need 1/00000000/1",
               overflow_o, sum_o, carry_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        c;
    logic [33:0] e;
    int          errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      drive(a, b, c);
      exp_q.push_back(ref_add(a, b, c));
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({carry_o, sum_o} !== e[32:0]
`ifdef CLA_OVERFLOW_EN
          || overflow_o !== e[33]
`endif
         ) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL b2b_%0d: %h+%h+%b got %b_%h, need %b_%h",
                   i, a, b, c, carry_o, sum_o, e[32], e[31:0]);
        errs++;
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'h2345_6789 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre: sum=%h carry=%b, need 23456789/0", sum_o, carry_o);
    end
    // new pair in flight, then reset between edges
    drive(32'hF000_0000, 32'h2000_0000, 1'b1);
    #2;
    areset_i = 1'b1;
    #1;
    n_tests++;
    if (sum_o !== 32'd0 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: sum=%h carry=%b, need 0/0", sum_o, carry_o);
    end
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'd0 || carry_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_discard: sum=%h carry=%b, need 0/0", sum_o, carry_o);
    end
    @(negedge clk_i);
    areset_i = 1'b0;
    a_i = 32'hF000_0000; b_i = 32'h2000_0000; carry_i = 1'b1;
    @(posedge clk_i); #1;
    n_tests++;
    if (sum_o !== 32'h1000_0001 || carry_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_resume: sum=%h carry=%b, need 10000001/1", sum_o, carry_o);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_carry_chain();
    test_max();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
